mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 Parameter TIMEOUT_CYCLES, default 255: BUSY-cycle limit before watchdog abort; legal range 1-255; used only when MEM_TIMEOUT_EN is defined.
- REQ-002 clk  in  1  sole clock; all state updates on rising edge.
- REQ-003 rst  in  1  reset; synchronous, active-high.
- REQ-004 valid_in  in  1  EX/MEM holds a live instruction.
- REQ-005 result_in  in  16  ALU result; memory byte address for loads/stores.
- REQ-006 B_in  in  16  store data.
- REQ-007 mem_to_reg_in, mem_write_in  in  1 each  load / store request.
- REQ-008 reg_write_in  in  1; reg_wr_sel_in  in  3; dump_in  in  1  writeback and halt controls.
- REQ-009 mem_addr  out  16; mem_wdata  out  16; mem_rd  out  1; mem_wr  out  1  data-memory request.
- REQ-010 mem_rdata  in  16; mem_done  in  1; mem_err  in  1  data-memory response.
- REQ-011 stall_out  out  1  freeze EX/MEM and earlier stages.
- REQ-012 wb_data_out  out  16; reg_wr_sel_out  out  3; reg_write_out  out  1; dump_out  out  1; valid_out  out  1; err_out  out  1  registered MEM/WB outputs.

Function
- REQ-013 FSM states: IDLE, BUSY; reset state IDLE.
- REQ-014 Memory op = valid_in & (mem_to_reg_in | mem_write_in); when both are set, mem_write_in wins and the op is a store.
- REQ-015 IDLE, memory op, result_in[0]=0: mem_rd or mem_wr high for exactly this cycle, mem_addr=result_in, mem_wdata=B_in, stall_out=1, next state BUSY.
- REQ-016 IDLE, memory op, result_in[0]=1 (misaligned): no request; next edge captures valid_out=1, err_out=1, reg_write_out=0; no stall.
- REQ-017 IDLE, non-memory valid op: next edge captures valid_out=1, wb_data_out=result_in, reg_write_out/reg_wr_sel_out/dump_out from inputs; latency 1 cycle, no stall.
- REQ-018 IDLE, valid_in=0: next edge captures a bubble: valid_out=0, reg_write_out=0, dump_out=0, err_out=0.
- REQ-019 BUSY: mem_rd=mem_wr=0, stall_out=1 while mem_done=0, and each edge captures a bubble.
- REQ-020 BUSY with mem_done=1: stall_out=0 that cycle; edge captures valid_out=1, wb_data_out=mem_rdata for loads or result_in for stores, reg_write_out=reg_write_in, err_out=mem_err; next state IDLE.
- REQ-021 mem_err=1 with mem_done=1: reg_write_out=0 is forced.
- REQ-022 mem_done or mem_err while in IDLE is ignored; memory latency is >=1 cycle.
- REQ-023 Upstream holds all *_in stable while stall_out=1; the block latches the load/store type at request time and does not re-sample it in BUSY.
- REQ-024 Back-to-back memory ops: the op following a mem_done cycle starts a new request in the very next IDLE cycle; no dead cycle is inserted.

Reset
- REQ-025 rst=1 at any edge forces IDLE and sets all registered outputs to 0 (wb_data_out=0x0000).
- REQ-026 rst during BUSY abandons the outstanding access; a later mem_done is ignored per REQ-022.
- REQ-027 mem_rd, mem_wr and stall_out are 0 during the reset cycle.

Configuration
- REQ-028 Macro MEM_TIMEOUT_EN: when defined, an 8-bit counter clears on entering BUSY and increments each BUSY cycle without mem_done.
- REQ-029 With MEM_TIMEOUT_EN, reaching TIMEOUT_CYCLES aborts the access: stall_out=0 that cycle, edge captures valid_out=1, err_out=1, reg_write_out=0, next state IDLE.
- REQ-030 Without MEM_TIMEOUT_EN, no counter is built and BUSY persists until mem_done.

Verification
- REQ-031 Aligned load at 0x0010, mem_done 3 cycles later with mem_rdata=0xBEEF -> mem_rd one cycle; stall_out=1 for 3 cycles; then valid_out=1, wb_data_out=0xBEEF, reg_write_out=1.
- REQ-032 Store 0x1234 to 0x0020 with mem_done 1 cycle later -> mem_wr one cycle, mem_wdata=0x1234, one stall cycle, reg_write_out=0.
- REQ-033 Load at 0x0011 -> no mem_rd; next cycle err_out=1, valid_out=1, reg_write_out=0; stall_out never asserted.
- REQ-034 ALU op, result 0x00FF, reg_wr_sel 5 -> next cycle wb_data_out=0x00FF, reg_wr_sel_out=5, stall_out=0.
- REQ-035 rst asserted mid-BUSY, then a stray mem_done -> state IDLE, all outputs 0, stray mem_done produces no output.
- REQ-036 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no mem_done -> abort after 4 BUSY cycles: err_out=1, stall_out drops.

Source files
------------

// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if -- data-memory request/response bus between the MEM stage and
// the data memory.
//
//   mem_addr   [15:0]  byte address of the access        (master -> slave)
//   mem_wdata  [15:0]  store data                        (master -> slave)
//   mem_rd             load strobe, one cycle per access (master -> slave)
//   mem_wr             store strobe, one cycle per access(master -> slave)
//   mem_rdata  [15:0]  load data, valid with mem_done    (slave -> master)
//   mem_done           access complete                   (slave -> master)
//   mem_err            access failed, valid with mem_done(slave -> master)
// ----------------------------------------------------------------------------
interface mem_stage_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_done, mem_err
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_done, mem_err
  );
endinterface : mem_stage_if

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage with a two-state (IDLE/BUSY) memory FSM.
//
// Non-memory instructions pass to the MEM/WB register in one cycle. Aligned
// loads/stores issue a one-cycle request on the memory bus and stall the
// upstream pipeline until mem_done. Misaligned accesses are not issued and
// retire immediately with err_out set.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   valid_in              EX/MEM holds a live instruction
//   result_in   [15:0]    ALU result / memory byte address
//   B_in        [15:0]    store data
//   mem_to_reg_in         load request
//   mem_write_in          store request (wins over load)
//   reg_write_in, reg_wr_sel_in[2:0], dump_in   writeback / halt controls
//   mem                   data-memory bus (mem_stage_if.master)
//   stall_out             freeze EX/MEM and earlier stages
//   wb_data_out[15:0], reg_wr_sel_out[2:0], reg_write_out, dump_out,
//   valid_out, err_out    registered MEM/WB outputs
//
// Configuration
//   MEM_TIMEOUT_EN        when defined, a BUSY watchdog aborts an access after
//                         TIMEOUT_CYCLES cycles in BUSY (legal range 1-255).
// ----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] result_in,
  input  logic [15:0] B_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic [2:0]  reg_wr_sel_in,
  input  logic        dump_in,
  mem_stage_if.master mem,
  output logic        stall_out,
  output logic [15:0] wb_data_out,
  output logic [2:0]  reg_wr_sel_out,
  output logic        reg_write_out,
  output logic        dump_out,
  output logic        valid_out,
  output logic        err_out
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic        is_store_q;
  logic [15:0] wb_data_q;
  logic [2:0]  reg_wr_sel_q;
  logic        reg_write_q;
  logic        dump_q;
  logic        valid_q;
  logic        err_q;

  logic mem_op;
  logic timeout;

  assign mem_op = valid_in & (mem_to_reg_in | mem_write_in);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;
  // The abort fires in the TIMEOUT_CYCLES-th BUSY cycle, which is when the
  // counter (cleared on entry) holds TIMEOUT_CYCLES-1.
  assign timeout = (tmo_cnt_q == TimeoutLast);
`else
  assign timeout = 1'b0;
`endif

  // Memory request and stall are combinational so the request goes out in the
  // same cycle the instruction is seen in IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = result_in;
    mem.mem_wdata = B_in;
    stall_out     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (mem_op && !result_in[0]) begin
            mem.mem_wr = mem_write_in;
            mem.mem_rd = ~mem_write_in;
            stall_out  = 1'b1;
          end
        end
        BUSY: stall_out = ~mem.mem_done & ~timeout;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      wb_data_q    <= 16'h0000;
      reg_wr_sel_q <= 3'd0;
      reg_write_q  <= 1'b0;
      dump_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q    <= 8'd0;
`endif
    end else begin
      // Bubble unless a branch below retires an instruction.
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      dump_q      <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (result_in[0]) begin
              valid_q      <= 1'b1;
              err_q        <= 1'b1;
              wb_data_q    <= result_in;
              reg_wr_sel_q <= reg_wr_sel_in;
            end else begin
              state_q    <= BUSY;
              is_store_q <= mem_write_in;
`ifdef MEM_TIMEOUT_EN
              tmo_cnt_q  <= 8'd0;
`endif
            end
          end else if (valid_in) begin
            valid_q      <= 1'b1;
            wb_data_q    <= result_in;
            reg_wr_sel_q <= reg_wr_sel_in;
            reg_write_q  <= reg_write_in;
            dump_q       <= dump_in;
          end
        end
        BUSY: begin
          if (mem.mem_done) begin
            state_q      <= IDLE;
            valid_q      <= 1'b1;
            wb_data_q    <= is_store_q ? result_in : mem.mem_rdata;
            reg_wr_sel_q <= reg_wr_sel_in;
            reg_write_q  <= reg_write_in & ~mem.mem_err;
            dump_q       <= dump_in;
            err_q        <= mem.mem_err;
          end else if (timeout) begin
            state_q      <= IDLE;
            valid_q      <= 1'b1;
            err_q        <= 1'b1;
            wb_data_q    <= result_in;
            reg_wr_sel_q <= reg_wr_sel_in;
          end else begin
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_data_out    = wb_data_q;
  assign reg_wr_sel_out = reg_wr_sel_q;
  assign reg_write_out  = reg_write_q;
  assign dump_out       = dump_q;
  assign valid_out      = valid_q;
  assign err_out        = err_q;

endmodule : mem_stage
